placement_cost_eval: RTL
========================

Name: placement_cost_eval

Overview:
- Streaming wire-length evaluator that sits directly downstream of the random placer.
- The placer, or its position-memory reader, presents one edge per transfer as the grid coordinates of both endpoints.
- The block accumulates the Manhattan and 1-hop evaluation costs, the longest edge and the count of unplaced edges, then reports totals with a done pulse.
- It replaces the placer's serial eval loop with a pipelined stage that accepts one edge per clock.

Parameters:
- W, 32, datapath width of coordinates and accumulators (signed, two's complement).
- CNT_W, 16, width of edge counters and of the n_edge configuration.
- UNPLACED, -1, coordinate value marking a node with no grid position.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
- start  input  1  one-cycle pulse that begins an evaluation run; ignored unless the block is idle.
- n_edge  input  CNT_W  number of edges in the run; sampled on the start cycle.
- in_valid  input  1  edge data valid.
- in_ready  output  1  block can accept an edge.
- ax, ay, bx, by  input  W  signed grid coordinates of endpoints A and B.
- busy  output  1  a run is in progress.
- done  output  1  one-cycle pulse; the result outputs are final in that cycle.
- sum  output  W  signed sum of (|dx|+|dy|-1) over placed edges.
- sum_1hop  output  W  signed sum of (ceil(|dx|/2)+ceil(|dy|/2)-1) over placed edges.
- max_dist  output  W  largest |dx|+|dy| over placed edges.
- unplaced_cnt  output  CNT_W  number of edges skipped because an endpoint is unplaced.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - in_ready, busy, done = 0.
  - sum, sum_1hop, max_dist, unplaced_cnt = 0.
  - Pipeline valid bits and counters are cleared.
  - Applies mid-run as well: the partial run is discarded and no done is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches n_edge, clears all results and counters, sets busy=1 and goes to RUN.
  - If n_edge==0, it goes straight to DRAIN instead.
- RUN:
  - in_ready = 1 while accepted < n_edge_latched.
  - A transfer happens when in_valid && in_ready.
  - When the final edge is accepted, in_ready drops the next cycle and the FSM goes to DRAIN.
- DRAIN: waits until all 3 pipeline stages are empty, then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then the FSM returns to IDLE.
  - Results hold until the next start or reset.
- Pipeline: 3 stages, throughput of one edge per cycle, no internal stalls. The accumulators reflect an edge accepted in cycle t at the end of cycle t+3.
  - S1: dx=ax-bx, dy=ay-by (W-bit). skip = (ax==UNPLACED)||(bx==UNPLACED)||(ay==UNPLACED)||(by==UNPLACED).
  - S2: absolute values, with -x computed as (~x)+1. dist=|dx|+|dy|. hop=(|dx|>>1)+|dx|[0]+(|dy|>>1)+|dy|[0].
  - S3:
    - If skip: unplaced_cnt+1, and sum, sum_1hop, max_dist are untouched.
    - Otherwise: sum+=dist-1, sum_1hop+=hop-1, and max_dist=dist if dist>max_dist.
- Accumulator width:
  - Accumulators wrap modulo 2^W with no saturation in the base build.
  - An overlapping edge (dist=0) is legal and adds -1 to both sums.
- start while busy: ignored, with no effect on the run in progress.
- in_valid while not in_ready: data ignored, not counted.
- unplaced_cnt saturates at all-ones.

Optional Feature:
- Macro: PLACEMENT_COST_CYCLES_EN.
- When defined:
  - Adds output port cycles (W bits), which counts clk edges from the start-accepted cycle through the DONE cycle inclusive.
  - cycles resets to 0 and holds after done.
  - Under simulation, the block prints "Evaluation = %d, Evaluation 1-hop = %d, Cycles = %d" once in the DONE cycle.
- When undefined: no cycles port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset with reset=0 for 2 cycles during RUN, mid-stream after 3 of 5 edges -> all outputs 0, state IDLE, no done; a following start runs cleanly.
- start with n_edge=2; edges (0,0)-(3,4) then (5,5)-(5,6), streamed back-to-back -> done 5 cycles after the first accept; sum=6+0=6; sum_1hop=(2+2-1)+(0+1-1)=3; max_dist=7; unplaced_cnt=0.
- n_edge=3 with the middle edge ax=-1 and the others (1,1)-(2,2) and (0,0)-(0,10) -> unplaced_cnt=1, sum=1+9=10, sum_1hop=1+4=5, max_dist=10.
- n_edge=4 with in_valid toggling 1,0,1,1,0,1 and a 5th extra edge presented -> exactly 4 accepted; in_ready=0 after the 4th; the extra edge has no effect on results.
- n_edge=0 -> done 2 cycles after start with all results 0; a start pulsed during busy of a prior n_edge=2 run is ignored and n_edge is not re-latched.
- Overlap edge (4,4)-(4,4) with n_edge=1 -> sum=-1 (all ones), sum_1hop=-1, max_dist=0; with PLACEMENT_COST_CYCLES_EN, cycles=6.

Source files
------------

// File: rtl/placement_cost_eval_if.sv
// Edge stream, run control and result bundle between the placer and placement_cost_eval.
interface placement_cost_eval_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 16
) ();
   logic                    start;
   logic [CNT_W-1:0]        n_edge;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [W-1:0]     ax;
   logic signed [W-1:0]     ay;
   logic signed [W-1:0]     bx;
   logic signed [W-1:0]     by;
   logic                    busy;
   logic                    done;
   logic signed [W-1:0]     sum;
   logic signed [W-1:0]     sum_1hop;
   logic signed [W-1:0]     max_dist;
   logic [CNT_W-1:0]        unplaced_cnt;

   modport master (
      output start, n_edge, in_valid, ax, ay, bx, by,
      input  in_ready, busy, done, sum, sum_1hop, max_dist, unplaced_cnt
   );

   modport slave (
      input  start, n_edge, in_valid, ax, ay, bx, by,
      output in_ready, busy, done, sum, sum_1hop, max_dist, unplaced_cnt
   );
endinterface

// File: rtl/placement_cost_eval.sv
// Pipelined wire-length evaluator: one edge per clock, Manhattan/1-hop sums, max edge, unplaced count.
// Optional PLACEMENT_COST_CYCLES_EN adds a run-length cycle counter output.
module placement_cost_eval #(
   parameter int unsigned      W        = 32,
   parameter int unsigned      CNT_W    = 16,
   parameter logic [W-1:0]     UNPLACED = W'(-1)
) (
   input  logic                  clk,
   input  logic                  reset,
   placement_cost_eval_if.slave  bus_io
`ifdef PLACEMENT_COST_CYCLES_EN
   ,
   output logic [W-1:0]          cycles_o
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] n_edge_q, n_edge_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

   logic             v1_q, v1_d, skip1_q, skip1_d;
   logic [W-1:0]     dx1_q, dx1_d, dy1_q, dy1_d;
   logic             v2_q, v2_d, skip2_q, skip2_d;
   logic [W-1:0]     adx2_q, adx2_d, ady2_q, ady2_d;
   logic             v3_q, v3_d, skip3_q, skip3_d;
   logic [W-1:0]     dist3_q, dist3_d, hop3_q, hop3_d;

   logic [W-1:0]     sum_q, sum_d, hop_sum_q, hop_sum_d, max_q, max_d;
   logic [CNT_W-1:0] unpl_q, unpl_d;

   logic             in_ready;
   logic             accept;
   logic             start_go;
   logic             last_edge;

   function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
      return x[W-1] ? (~x) + W'(1) : x;
   endfunction

   assign in_ready  = (state_q == StRun) && (acc_cnt_q < n_edge_q);
   assign accept    = bus_io.in_valid && in_ready;
   assign start_go  = (state_q == StIdle) && bus_io.start;
   assign last_edge = (acc_cnt_q + CNT_W'(1)) == n_edge_q;

   always_comb begin
      state_d   = state_q;
      n_edge_d  = n_edge_q;
      acc_cnt_d = acc_cnt_q;

      v1_d    = accept;
      dx1_d   = bus_io.ax - bus_io.bx;
      dy1_d   = bus_io.ay - bus_io.by;
      skip1_d = (bus_io.ax == UNPLACED) || (bus_io.bx == UNPLACED) ||
                (bus_io.ay == UNPLACED) || (bus_io.by == UNPLACED);

      v2_d    = v1_q;
      adx2_d  = abs_w(dx1_q);
      ady2_d  = abs_w(dy1_q);
      skip2_d = skip1_q;

      v3_d    = v2_q;
      dist3_d = adx2_q + ady2_q;
      hop3_d  = (adx2_q >> 1) + W'(adx2_q[0]) + (ady2_q >> 1) + W'(ady2_q[0]);
      skip3_d = skip2_q;

      sum_d     = sum_q;
      hop_sum_d = hop_sum_q;
      max_d     = max_q;
      unpl_d    = unpl_q;

      if (v3_q) begin
         if (skip3_q) begin
            if (unpl_q != '1) unpl_d = unpl_q + CNT_W'(1);
         end else begin
            sum_d     = sum_q + dist3_q - W'(1);
            hop_sum_d = hop_sum_q + hop3_q - W'(1);
            if ($signed(dist3_q) > $signed(max_q)) max_d = dist3_q;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               n_edge_d  = bus_io.n_edge;
               acc_cnt_d = '0;
               sum_d     = '0;
               hop_sum_d = '0;
               max_d     = '0;
               unpl_d    = '0;
               state_d   = (bus_io.n_edge == '0) ? StDrain : StRun;
            end
         end
         StRun: begin
            if (accept) begin
               acc_cnt_d = acc_cnt_q + CNT_W'(1);
               if (last_edge) state_d = StDrain;
            end
         end
         // Stage 3 retires its edge this cycle, so only stages 1-2 gate the exit.
         StDrain: if (!v1_q && !v2_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         n_edge_q  <= '0;
         acc_cnt_q <= '0;
         v1_q      <= 1'b0;
         skip1_q   <= 1'b0;
         dx1_q     <= '0;
         dy1_q     <= '0;
         v2_q      <= 1'b0;
         skip2_q   <= 1'b0;
         adx2_q    <= '0;
         ady2_q    <= '0;
         v3_q      <= 1'b0;
         skip3_q   <= 1'b0;
         dist3_q   <= '0;
         hop3_q    <= '0;
         sum_q     <= '0;
         hop_sum_q <= '0;
         max_q     <= '0;
         unpl_q    <= '0;
      end else begin
         state_q   <= state_d;
         n_edge_q  <= n_edge_d;
         acc_cnt_q <= acc_cnt_d;
         v1_q      <= v1_d;
         skip1_q   <= skip1_d;
         dx1_q     <= dx1_d;
         dy1_q     <= dy1_d;
         v2_q      <= v2_d;
         skip2_q   <= skip2_d;
         adx2_q    <= adx2_d;
         ady2_q    <= ady2_d;
         v3_q      <= v3_d;
         skip3_q   <= skip3_d;
         dist3_q   <= dist3_d;
         hop3_q    <= hop3_d;
         sum_q     <= sum_d;
         hop_sum_q <= hop_sum_d;
         max_q     <= max_d;
         unpl_q    <= unpl_d;
      end
   end

   assign bus_io.in_ready     = in_ready;
   assign bus_io.busy         = (state_q == StRun) || (state_q == StDrain);
   assign bus_io.done         = (state_q == StDone);
   assign bus_io.sum          = sum_q;
   assign bus_io.sum_1hop     = hop_sum_q;
   assign bus_io.max_dist     = max_q;
   assign bus_io.unplaced_cnt = unpl_q;

`ifdef PLACEMENT_COST_CYCLES_EN
   logic [W-1:0] cyc_q, cyc_d;

   // The start cycle counts as 1; the DONE cycle's own edge is the last one counted.
   always_comb begin
      cyc_d = cyc_q;
      if (start_go)               cyc_d = W'(1);
      else if (state_q != StIdle) cyc_d = cyc_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) cyc_q <= '0;
      else        cyc_q <= cyc_d;
   end

   assign cycles_o = cyc_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && state_q == StDone) begin
         $display("Evaluation = %d, Evaluation 1-hop = %d, Cycles = %d",
                  $signed(sum_q), $signed(hop_sum_q), cyc_q + W'(1));
      end
   end
`endif
`endif

endmodule
